// File: rtl/lsu_pkg.sv
// Shared types and RISC-V funct3 encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Moves the addressed lane of a memory word down to bit 0 and applies
// sign or zero extension according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        word_s  = shifted[31:0];
        case (funct3)
            LB:      result = XLEN'(byte_s);
            LH:      result = XLEN'(half_s);
            LW:      result = XLEN'(word_s);
            LBU:     result = XLEN'(shifted[7:0]);
            LHU:     result = XLEN'(shifted[15:0]);
            LWU:     result = XLEN'(shifted[31:0]);
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_handshake.sv
// Load/store unit: checks and launches one data-memory access at a time,
// stalls the pipeline until memory answers or times out, returns load data.
module lsu_handshake
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              access_err,
    output logic              timeout_err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_mask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t      state, state_nxt;
    logic [7:0]      wait_cnt;
    logic [2:0]      funct3_q;
    logic [2:0]      offset_q;
    logic [4:0]      rd_q;
    logic            req_mem;
    logic            is_legal;
    logic            accept;
    logic            busy_timeout;
    logic            busy_hit;
    logic [2:0]      req_off;
    logic [NB-1:0]   mask_c;
    logic [XLEN-1:0] load_data;

    function automatic logic legal_req(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [2:0] addr_lo);
        logic       f3_ok;
        logic [2:0] align_m;
        if (ld)
            f3_ok = (f3 != 3'b111) && ((XLEN == 64) || ((f3 != LD) && (f3 != LWU)));
        else
            f3_ok = !f3[2] && ((XLEN == 64) || (f3 != SD));
        align_m = 3'(size_bytes(f3[1:0]) - 4'd1);
        return !(ld && st) && f3_ok && ((addr_lo & align_m) == 3'b000);
    endfunction

    assign req_mem      = req_valid && (req_load || req_store);
    assign is_legal     = legal_req(req_load, req_store, req_funct3, req_addr[2:0]);
    assign accept       = (state == IDLE) && req_mem && is_legal;
    assign req_off      = 3'(req_addr[OFF_W-1:0]);
    assign mask_c       = NB'(((16'd1 << size_bytes(req_funct3[1:0])) - 16'd1) << req_off);
    // The timeout cycle wins over a late mem_valid; the request is already down by then.
    assign busy_timeout = (state == BUSY) && (wait_cnt == 8'(MAX_WAIT));
    assign busy_hit     = (state == BUSY) && mem_valid && !busy_timeout;
    assign stall        = accept || (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (busy_timeout || busy_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .data   (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_data)
    );

    // Registered outputs and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            access_err  <= 1'b0;
            rsp_valid   <= 1'b0;
            timeout_err <= 1'b0;
            rsp_rd      <= '0;
            rsp_rdata   <= '0;
            mem_request <= 1'b0;
            mem_we_re   <= 1'b0;
            mem_addr    <= '0;
            mem_mask    <= '0;
            mem_wdata   <= '0;
        end else begin
            access_err  <= (state == IDLE) && req_mem && !is_legal;
            rsp_valid   <= busy_timeout || busy_hit;
            timeout_err <= busy_timeout;
            rsp_rd      <= (busy_timeout || busy_hit) ? rd_q : '0;
            rsp_rdata   <= (busy_hit && !mem_we_re) ? load_data : '0;
            if (accept) begin
                wait_cnt    <= '0;
                mem_request <= 1'b1;
                mem_we_re   <= req_store;
                mem_addr    <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                mem_mask    <= mask_c;
                mem_wdata   <= req_wdata << {req_off, 3'b000};
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
                if (busy_hit || ((9'(wait_cnt) + 9'd1) == 9'(MAX_WAIT)))
                    mem_request <= 1'b0;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Access context kept for the response
    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= req_funct3;
            offset_q <= req_off;
            rd_q     <= req_rd;
        end
    end

endmodule

// File: tb/tb_lsu_handshake.sv
// Scoreboard bench for lsu_handshake: one XLEN=32 and one XLEN=64 instance
// driven by directed accesses with hand-computed expectations.
module tb_lsu_handshake;

    localparam int MAXW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        req_valid32 = 1'b0, req_valid64 = 1'b0;
    logic        req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_valid = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        stall32, rsp_valid32, access_err32, timeout_err32, mem_request32, mem_we_re32;
    logic [31:0] rsp_rdata32, mem_addr32, mem_wdata32;
    logic [4:0]  rsp_rd32;
    logic [3:0]  mem_mask32;
    logic        stall64, rsp_valid64, access_err64, timeout_err64, mem_request64, mem_we_re64;
    logic [63:0] rsp_rdata64, mem_addr64, mem_wdata64;
    logic [4:0]  rsp_rd64;
    logic [7:0]  mem_mask64;

    lsu_handshake #(.XLEN(32), .MAX_WAIT(MAXW)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid32), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .req_rd(req_rd), .stall(stall32),
        .rsp_valid(rsp_valid32), .rsp_rdata(rsp_rdata32), .rsp_rd(rsp_rd32),
        .access_err(access_err32), .timeout_err(timeout_err32),
        .mem_request(mem_request32), .mem_we_re(mem_we_re32), .mem_addr(mem_addr32),
        .mem_mask(mem_mask32), .mem_wdata(mem_wdata32), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata[31:0])
    );

    lsu_handshake #(.XLEN(64), .MAX_WAIT(MAXW)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid64), .req_load(req_load),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall64),
        .rsp_valid(rsp_valid64), .rsp_rdata(rsp_rdata64), .rsp_rd(rsp_rd64),
        .access_err(access_err64), .timeout_err(timeout_err64),
        .mem_request(mem_request64), .mem_we_re(mem_we_re64), .mem_addr(mem_addr64),
        .mem_mask(mem_mask64), .mem_wdata(mem_wdata64), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          dut;
        bit          err;
        int          cyc;
        logic [63:0] rdata;
        logic [4:0]  rd;
        bit          tmo;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic rv, input logic ae, input logic te,
                       input logic [63:0] rdata, input logic [4:0] rd);
        exp_t e;
        if (rv || ae) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp dut=%0d rsp_valid=%0b access_err=%0b expected=none",
                         d, rv, ae);
            end else begin
                e = sb.pop_front();
                chk("rsp_dut", 64'(d), 64'(e.dut));
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("access_err", 64'(ae), 64'(e.err));
                chk("rsp_valid", 64'(rv), 64'(!e.err));
                if (!e.err) begin
                    chk("timeout_err", 64'(te), 64'(e.tmo));
                    chk("rsp_rdata", rdata, e.rdata);
                    chk("rsp_rd", 64'(rd), 64'(e.rd));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, rsp_valid32, access_err32, timeout_err32, 64'(rsp_rdata32), rsp_rd32);
        mon(1, rsp_valid64, access_err64, timeout_err64, rsp_rdata64, rsp_rd64);
    end

    // delay < 0 means memory never answers
    task automatic access(input string nm, input bit d64, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input int delay, input logic [63:0] rdata,
                          input bit bad, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_rdata);
        exp_t        e;
        int          lat, t0, n_stall, n_req;
        logic [63:0] amask;
        lat   = bad ? 1 : ((delay < 0) ? MAXW + 2 : delay + 2);
        amask = d64 ? ~64'h7 : ~64'h3;
        @(posedge clk); #1;
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd; mem_rdata = rdata;
        if (d64) req_valid64 = 1'b1; else req_valid32 = 1'b1;
        t0 = cyc;
        e.dut = d64 ? 1 : 0; e.err = bad; e.cyc = t0 + lat;
        e.rdata = exp_rdata; e.rd = rd; e.tmo = (delay < 0);
        sb.push_back(e);
        n_stall = 0;
        n_req = 0;
        for (int k = 0; k < lat + 2; k++) begin
            mem_valid = (delay >= 0) && (k == delay + 1);
            @(negedge clk);
            n_stall += int'(d64 ? stall64 : stall32);
            n_req   += int'(d64 ? mem_request64 : mem_request32);
            if (k == 1 && !bad) begin
                chk({nm, "_mem_mask"}, d64 ? 64'(mem_mask64) : 64'(mem_mask32), 64'(exp_mask));
                chk({nm, "_mem_addr"}, d64 ? mem_addr64 : 64'(mem_addr32), addr & amask);
                chk({nm, "_mem_wdata"}, d64 ? mem_wdata64 : 64'(mem_wdata32), exp_wdata);
                chk({nm, "_mem_we_re"}, 64'(d64 ? mem_we_re64 : mem_we_re32), 64'(st));
            end
            @(posedge clk); #1;
            req_valid32 = 1'b0;
            req_valid64 = 1'b0;
        end
        mem_valid = 1'b0;
        chk({nm, "_stall_cycles"}, 64'(n_stall), 64'(bad ? 0 : lat));
        chk({nm, "_mem_request_cycles"}, 64'(n_req),
            64'(bad ? 0 : ((delay < 0) ? MAXW : delay + 1)));
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs32", {stall32, rsp_valid32, access_err32, timeout_err32,
                                mem_request32, mem_we_re32, mem_mask32, rsp_rd32}, 64'd0);
        chk("reset_data32", 64'(rsp_rdata32 | mem_addr32 | mem_wdata32), 64'd0);
        chk("reset_outputs64", {stall64, rsp_valid64, access_err64, timeout_err64,
                                mem_request64, mem_we_re64, mem_mask64, rsp_rd64}, 64'd0);
        chk("reset_data64", rsp_rdata64 | mem_addr64 | mem_wdata64, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //      name        64 ld st f3      addr      wdata         rd   dly rdata          bad mask   wdata_exp     rdata_exp
        access("sw_late",   0, 0, 1, 3'b010, 64'h104,  64'hDEADBEEF, 5'd0, 3, 64'h12345678, 0, 8'hF, 64'hDEADBEEF, 64'h0);
        access("lb_neg",    0, 1, 0, 3'b000, 64'h103,  64'h0,        5'd7, 0, 64'h80FFFFFF, 0, 8'h8, 64'h0,        64'hFFFFFF80);
        access("lhu",       0, 1, 0, 3'b101, 64'h102,  64'h0,        5'd9, 0, 64'hABCD1234, 0, 8'hC, 64'h0,        64'h0000ABCD);
        access("lh_misal",  0, 1, 0, 3'b001, 64'h101,  64'h0,        5'd9, 0, 64'h0,        1, 8'h0, 64'h0,        64'h0);
        access("lh_neg",    0, 1, 0, 3'b001, 64'h102,  64'h0,        5'd3, 1, 64'h80010000, 0, 8'hC, 64'h0,        64'hFFFF8001);
        access("lw",        0, 1, 0, 3'b010, 64'h108,  64'h0,        5'd31,2, 64'hCAFEF00D, 0, 8'hF, 64'h0,        64'hCAFEF00D);
        access("sb_lane2",  0, 0, 1, 3'b000, 64'h106,  64'h000000AB, 5'd0, 0, 64'h0,        0, 8'h4, 64'h00AB0000, 64'h0);
        access("sh_lane2",  0, 0, 1, 3'b001, 64'h10A,  64'h00005678, 5'd0, 1, 64'h0,        0, 8'hC, 64'h56780000, 64'h0);
        access("ld_and_st", 0, 1, 1, 3'b010, 64'h100,  64'h0,        5'd1, 0, 64'h0,        1, 8'h0, 64'h0,        64'h0);
        access("lwu_rv32",  0, 1, 0, 3'b110, 64'h100,  64'h0,        5'd1, 0, 64'h0,        1, 8'h0, 64'h0,        64'h0);
        access("st_zext",   0, 0, 1, 3'b100, 64'h100,  64'h0,        5'd1, 0, 64'h0,        1, 8'h0, 64'h0,        64'h0);
        access("sw_misal",  0, 0, 1, 3'b010, 64'h102,  64'h0,        5'd1, 0, 64'h0,        1, 8'h0, 64'h0,        64'h0);
        access("timeout",   0, 1, 0, 3'b010, 64'h200,  64'h0,        5'd4, -1,64'h0,        0, 8'hF, 64'h0,        64'h0);
        access("sd",        1, 0, 1, 3'b011, 64'h1008, 64'h0123456789ABCDEF, 5'd0, 0, 64'h5555, 0, 8'hFF, 64'h0123456789ABCDEF, 64'h0);
        access("lwu",       1, 1, 0, 3'b110, 64'h1004, 64'h0, 5'd12, 0, 64'h80000001DEADBEEF, 0, 8'hF0, 64'h0, 64'h0000000080000001);
        access("lw64",      1, 1, 0, 3'b010, 64'h1004, 64'h0, 5'd13, 1, 64'h80000001DEADBEEF, 0, 8'hF0, 64'h0, 64'hFFFFFFFF80000001);
        access("ld_misal",  1, 1, 0, 3'b011, 64'h1004, 64'h0, 5'd2, 0, 64'h0, 1, 8'h0, 64'h0, 64'h0);
        access("ld",        1, 1, 0, 3'b011, 64'h1000, 64'h0, 5'd14, 1, 64'hFEDCBA9876543210, 0, 8'hFF, 64'h0, 64'hFEDCBA9876543210);
        access("sb_lane7",  1, 0, 1, 3'b000, 64'h1007, 64'h5A, 5'd0, 0, 64'h0, 0, 8'h80, 64'h5A00000000000000, 64'h0);

        // Neither load nor store: request is ignored
        @(posedge clk); #1;
        req_load = 1'b0; req_store = 1'b0; req_valid32 = 1'b1;
        @(negedge clk);
        chk("ignored_stall", 64'(stall32), 64'd0);
        @(posedge clk); #1;
        req_valid32 = 1'b0;
        @(negedge clk);
        chk("ignored_mem_request", 64'(mem_request32), 64'd0);

        // Reset while a load is waiting on memory
        @(posedge clk); #1;
        req_load = 1'b1; req_funct3 = 3'b010; req_addr = 64'h300; req_rd = 5'd6;
        req_valid32 = 1'b1;
        @(posedge clk); #1;
        req_valid32 = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy_mem_request", 64'(mem_request32), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", {stall32, mem_request32, mem_we_re32, mem_mask32,
                               rsp_valid32, access_err32, timeout_err32}, 64'd0);
        chk("rst_async_addr", 64'(mem_addr32), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 64'h11223344;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n += int'(rsp_valid32);
            @(posedge clk); #1;
            mem_valid = 1'b0;
        end
        chk("rst_no_response", 64'(n), 64'd0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
